// File: rtl/nibble_mux_arbiter_if.sv
// rtl/nibble_mux_arbiter_if.sv - requester/mux bundle for the nibble mux arbiter
interface nibble_mux_arbiter_if #(
  parameter int NREQ = 4
);
  logic              en;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   last;
  logic [4*NREQ-1:0] data_in;
  logic [NREQ-1:0]   grant;
  logic [3:0]        mux_a;
  logic [5:0]        mux_sel;
  logic              beat_valid;
  logic              busy;

  modport master (
    output en, req, last, data_in,
    input  grant, mux_a, mux_sel, beat_valid, busy
  );

  modport slave (
    input  en, req, last, data_in,
    output grant, mux_a, mux_sel, beat_valid, busy
  );
endinterface

// File: rtl/nibble_mux_arbiter.sv
// rtl/nibble_mux_arbiter.sv - round-robin burst arbiter driving the 4-bit pass-through mux
module nibble_mux_arbiter #(
  parameter int NREQ     = 4,
  parameter int HOLD_MAX = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  nibble_mux_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state;
  logic [NREQ-1:0] grant_q;
  logic [5:0]      sel_q;
  logic [PW-1:0]   ptr;
  logic [BW-1:0]   beats;

  logic [NREQ-1:0] pick_oh;
  logic            pick_found;
  logic [PW-1:0]   cand;
  logic [PW-1:0]   gidx;
  logic [PW-1:0]   next_ptr;
  logic [3:0]      mux_a_c;
  logic            req_g;
  logic            last_g;
  logic            term;

  // Rotating search: first requester at or after ptr, wrapping past NREQ-1.
  always_comb begin
    pick_oh    = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (!pick_found && bus.req[cand]) begin
        pick_oh[cand] = 1'b1;
        pick_found    = 1'b1;
      end
    end
  end

  always_comb begin
    gidx    = '0;
    mux_a_c = 4'b0000;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        gidx    = PW'(i);
        mux_a_c = bus.data_in[4*i +: 4];
      end
    end
  end

  assign req_g    = |(bus.req & grant_q);
  assign last_g   = |(bus.last & grant_q);
  assign term     = !req_g || last_g || (beats == BW'(HOLD_MAX));
  assign next_ptr = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant_q <= '0;
      sel_q   <= 6'b000000;
      ptr     <= '0;
      beats   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.en && (|bus.req)) begin
            grant_q <= pick_oh;
            sel_q   <= 6'b111111;
            beats   <= BW'(1);
            state   <= PASS;
          end
        end
        PASS: begin
          if (term) begin
            grant_q <= '0;
            sel_q   <= 6'b000000;
            ptr     <= next_ptr;
            state   <= GAP;
          end else if (beats != BW'(HOLD_MAX)) begin
            beats <= beats + 1'b1;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.mux_sel    = sel_q;
  assign bus.mux_a      = mux_a_c;
  assign bus.beat_valid = (state == PASS) && req_g;
  assign bus.busy       = (state != IDLE);
endmodule

// File: doc/nibble_mux_arbiter.md
# nibble_mux_arbiter

Round-robin controller that shares the fixed/variable 4-bit pass-through mux between `NREQ` requesters. It grants one requester at a time and drives the mux data input with that requester's nibble. It drives the 6-bit selector to the pass code `6'b111111` for the duration of a burst. Between bursts it drives selector `6'b000000`, so the mux emits its fixed `4'b0101` idle pattern. It sits directly in front of the mux and is the only driver of its `a` and `c` inputs.

## Interface
- `NREQ`, 4: number of requesters; legal range 2..8.
- `HOLD_MAX`, 8: maximum beats per burst; legal range 1..255.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `en` input 1: arbitration enable; 0 blocks new grants, and an in-flight burst completes normally.
- `req` input NREQ: request per requester, level.
- `last` input NREQ: final-beat marker per requester; only the granted bit is observed.
- `data_in` input 4*NREQ: nibble per requester; requester i occupies bits [4i+3:4i].
- `grant` output NREQ: one-hot grant, registered.
- `mux_a` output 4: to mux data input; `data_in` of the granted requester, 4'b0000 when no grant. Combinational from registered `grant`.
- `mux_sel` output 6: to mux selector; 6'b111111 in PASS, otherwise 6'b000000. Registered.
- `beat_valid` output 1: PASS and `req[g]`=1 (g = granted index).
- `busy` output 1: state is not IDLE.

## Operation
- **States:** IDLE, PASS, GAP; 2-bit encoding, IDLE=0.
- **IDLE**
  - If `en`=1 and `req`≠0, pick the first set bit searching from `ptr` upward with wrap (ptr, ptr+1, …, NREQ-1, 0, …).
  - Register the one-hot grant, load `beats`=1, go to PASS.
  - Otherwise stay in IDLE.
- **PASS**
  - Every cycle is one beat.
  - Terminate on any of: `req[g]`=0, or `last[g]`=1, or `beats`==HOLD_MAX.
  - On termination, go to GAP, clear `grant`, and set `ptr` = (g+1) mod NREQ.
  - Otherwise `beats` increments, saturating at HOLD_MAX. `en` is ignored in PASS.
- **GAP**
  - Exactly one cycle with `grant`=0 and `mux_sel`=0, so the mux outputs 0101 as a burst separator.
  - Always returns to IDLE; no arbitration is performed in GAP.
- **Counter:** `beats` is an unsigned counter, width = clog2(HOLD_MAX+1).
- **ptr:** round-robin pointer, width clog2(NREQ), reset 0. It advances only at burst end, so a requester that is skipped keeps its priority position.
- **Unused requester bits:** `last` and `data_in` of non-granted requesters have no effect.
- **Reset:** asynchronous assertion at any time, including mid-burst. On reset: state=IDLE, `grant`=0, `mux_sel`=6'b000000, `ptr`=0, `beats`=0. Hence `mux_a`=0, `beat_valid`=0, `busy`=0. On release, arbitration resumes from the first rising edge.

## Timing
- **Request to grant latency:** `req` sampled high in IDLE at edge N gives `grant`, `mux_sel`=3F and `busy`=1 valid after edge N. The first beat is cycle N+1.
- **`mux_a` timing:** follows `data_in` in the same cycle (combinational) while granted.
- **Burst length:** L beats where L = min(index of `last`, HOLD_MAX). Then 1 GAP cycle.
- **Minimum turnaround:** end of burst to next grant is 2 cycles (GAP, then IDLE arbitration).
- **`last` and `req` drop together:** single termination; identical result.
- **`last` on first beat:** burst length 1.
- **HOLD_MAX=1:** every burst is 1 beat.
- **`en` deasserted during PASS:** the burst finishes. After GAP the block stays in IDLE until `en`=1.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-simulation with `req`=4'b1111 → same instant: `grant`=0, `mux_sel`=6'h00, `mux_a`=0, `busy`=0. After release, first grant is requester 0.
- **Single burst:** `req`=4'b0001, `data_in[3:0]`=4'hA, `last[0]` pulsed on the 3rd beat → `grant`=0001 and `mux_sel`=6'h3F for 3 cycles with `mux_a`=A. Then 1 cycle of `mux_sel`=0, then IDLE. Checked against a mux model, the output reads A,A,A,5.
- **Round-robin with saturation:** `req`=4'b1111 held, `last`=0, HOLD_MAX=8 → grants 0,1,2,3,0 in order. Each burst is exactly 8 PASS cycles with a 2-cycle gap between bursts.
- **Skip and wrap:** `ptr`=2 and `req`=4'b0011 → grant goes to requester 0, then to requester 1.
- **Early abort:** requester 1 drops `req` on its 2nd beat → transition to GAP on that edge, and `ptr` advances to 2.
- **Enable gating:** `en`=0 with `req`=4'b0100 → no grant and `busy`=0. Raise `en` → grant 0100 on the next edge. Dropping `en` mid-burst does not shorten the burst.
